odo_sbox_bank: RTL and testbench
================================

ODO_SBOX_BANK -- requirements
Module: odo_sbox_bank

Interface
REQ-001 SHALL have parameter W, default 6, meaning S-box input/output width in bits; table depth 2^W.
REQ-002 SHALL have parameter LANES, default 4, meaning parallel lookups per transfer.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, lookup request valid.
REQ-006 SHALL have port in_ready, output, 1, lookup request accepted when high with in_valid.
REQ-007 SHALL have port in_data, input, LANES*W, lane k at bits [k*W+W-1:k*W].
REQ-008 SHALL have port out_valid, output, 1, result valid.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-010 SHALL have port out_data, output, LANES*W, lane k = table[in lane k].
REQ-011 SHALL have port wr_en, input, 1, write one shadow-table entry.
REQ-012 SHALL have port wr_addr, input, W, shadow entry index.
REQ-013 SHALL have port wr_data, input, W, shadow entry value.
REQ-014 SHALL have port swap, input, 1, request exchange of active and shadow tables.
REQ-015 SHALL have port active_bank, output, 1, index of table used for lookups.
REQ-016 SHALL have port shadow_ready, output, 1, shadow table fully loaded since last swap.
REQ-017 SHALL have port swap_err, output, 1, one-cycle pulse: swap request rejected.

Function
REQ-018 SHALL hold two tables (bank 0, bank 1), each 2^W x W; the non-active bank is the shadow.
REQ-019 SHALL initialise both banks to identity (entry i = i) at configuration; rst SHALL NOT alter table contents.
REQ-020 SHALL accept a request when in_valid && in_ready; in_ready = out_ready || !out_valid.
REQ-021 SHALL on acceptance register all LANES lookups from the active bank as of that cycle into out_data and set out_valid the next cycle (latency 1).
REQ-022 SHALL hold out_data and out_valid stable while out_valid && !out_ready; full throughput (1 transfer/cycle) when out_ready is held high.
REQ-023 SHALL clear out_valid when out_valid && out_ready and no new request is accepted.
REQ-024 SHALL on wr_en write wr_data to shadow[wr_addr]; writes SHALL never touch the active bank.
REQ-025 SHALL count shadow writes in a W+1-bit counter, saturating at 2^W; shadow_ready = (count == 2^W); address order and duplicates are not checked.
REQ-026 SHALL accept swap when swap && shadow_ready && !wr_en: toggle active_bank next cycle, clear count to 0.
REQ-027 SHALL reject swap when !shadow_ready or wr_en is high in the same cycle: active_bank and count unchanged, swap_err high the next cycle for one cycle; a simultaneous wr_en is still performed.
REQ-028 SHALL use the pre-swap active bank for a request accepted in the same cycle as an accepted swap; requests accepted from the following cycle use the new bank.
REQ-029 SHALL NOT alter a held (stalled) out_data when a swap or shadow write occurs.

Reset
REQ-030 SHALL on rst drive out_valid=0, out_data=0, active_bank=0, count=0, shadow_ready=0, swap_err=0; in_ready=1 the cycle after.
REQ-031 SHALL make rst dominate all inputs in the same cycle; requests, writes and swaps coincident with rst are discarded.

Verification
REQ-032 SHALL cover: after rst, W=6, LANES=4, in_data={6'h3f,6'h2a,6'h01,6'h00}, out_ready=1 -> next cycle out_valid=1, out_data={6'h3f,6'h2a,6'h01,6'h00}.
REQ-033 SHALL cover: write shadow[i]=i^6'h15 for i=0..63, swap -> active_bank=1, shadow_ready=0; lookup 6'h00 returns 6'h15, 6'h3f returns 6'h2a.
REQ-034 SHALL cover: swap after only 63 writes -> swap_err pulses once, active_bank unchanged, lookups still identity.
REQ-035 SHALL cover: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_data frozen; on out_ready=1 results drain in order without loss or duplication.
REQ-036 SHALL cover: swap accepted in same cycle as request for 6'h05 -> that result uses old bank (6'h05); request next cycle uses new bank.
REQ-037 SHALL cover: rst asserted while out_valid=1 and count=40 -> out_valid=0, count=0, active_bank=0 next cycle; table contents retained.

Source files
------------

// File: rtl/odo_sbox_bank.sv
// Double-buffered S-box lookup bank: LANES parallel lookups per transfer,
// with a shadow table that is loaded entry by entry and swapped in atomically.
module odo_sbox_bank #(
    parameter int W     = 6,
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] out_data,
    input  logic               wr_en,
    input  logic [W-1:0]       wr_addr,
    input  logic [W-1:0]       wr_data,
    input  logic               swap,
    output logic               active_bank,
    output logic               shadow_ready,
    output logic               swap_err
);

    localparam int DEPTH = 1 << W;

    typedef logic [DEPTH-1:0][W-1:0] tbl_t;

    function automatic tbl_t identity();
        tbl_t t;
        for (int i = 0; i < DEPTH; i++) begin
            t[i] = W'(i);
        end
        return t;
    endfunction

    // Tables power up as identity and are deliberately outside reset.
    tbl_t bank0 = identity();
    tbl_t bank1 = identity();

    logic [W:0]         count;
    logic               swap_ok;
    logic               accept;
    logic [LANES*W-1:0] lookup;

    assign shadow_ready = (count == (W+1)'(DEPTH));
    assign swap_ok      = swap && shadow_ready && !wr_en;
    assign in_ready     = out_ready || !out_valid;
    assign accept       = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            if (active_bank) begin
                bank0[wr_addr] <= wr_data;
            end else begin
                bank1[wr_addr] <= wr_data;
            end
        end
    end

    always_comb begin
        lookup = '0;
        for (int k = 0; k < LANES; k++) begin
            lookup[k*W +: W] = active_bank ? bank1[in_data[k*W +: W]]
                                           : bank0[in_data[k*W +: W]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_bank <= 1'b0;
            count       <= '0;
            swap_err    <= 1'b0;
        end else begin
            swap_err <= swap && !swap_ok;
            if (swap_ok) begin
                active_bank <= ~active_bank;
                count       <= '0;
            end else if (wr_en && !shadow_ready) begin
                count <= count + 1'b1;
            end
        end
    end

    // A stalled result is only replaced when a new request is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= lookup;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_odo_sbox_bank.sv
// Scenario-driven bench for odo_sbox_bank with a reference table model
// and an in-order result scoreboard.
module tb_odo_sbox_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] out_data;
    logic        wr_en = 1'b0;
    logic [5:0]  wr_addr = '0;
    logic [5:0]  wr_data = '0;
    logic        swap = 1'b0;
    logic        active_bank;
    logic        shadow_ready;
    logic        swap_err;

    int total = 0;
    int bad = 0;
    bit started = 1'b0;

    logic [5:0]  mtbl [2][64];
    bit          mact = 1'b0;
    int          mcnt = 0;
    bit          merr = 1'b0;
    logic [23:0] q [$];

    always #5 clk = ~clk;

    odo_sbox_bank #(.W(6), .LANES(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .swap(swap), .active_bank(active_bank),
        .shadow_ready(shadow_ready), .swap_err(swap_err)
    );

    function automatic logic [23:0] look(input logic [23:0] d);
        logic [23:0] r;
        for (int k = 0; k < 4; k++) begin
            r[k*6 +: 6] = mtbl[int'(mact)][d[k*6 +: 6]];
        end
        return r;
    endfunction

    // Scoreboard: push on acceptance, pop and compare on transfer.
    always @(negedge clk) begin
        if (started) begin
            bit acc;
            bit sw_ok;
            logic [23:0] e;
            total++;
            if (active_bank !== mact) begin
                bad++;
                $display("FAIL mon_active got=%b want=%b", active_bank, mact);
            end
            total++;
            if (shadow_ready !== (mcnt == 64)) begin
                bad++;
                $display("FAIL mon_shadow_ready got=%b want=%b",
                         shadow_ready, (mcnt == 64));
            end
            total++;
            if (swap_err !== merr) begin
                bad++;
                $display("FAIL mon_swap_err got=%b want=%b", swap_err, merr);
            end
            total++;
            if (out_valid !== (q.size() != 0)) begin
                bad++;
                $display("FAIL mon_out_valid got=%b want=%b",
                         out_valid, (q.size() != 0));
            end
            total++;
            if (in_ready !== (out_ready || q.size() == 0)) begin
                bad++;
                $display("FAIL mon_in_ready got=%b want=%b",
                         in_ready, (out_ready || q.size() == 0));
            end
            if (rst) begin
                mact = 1'b0;
                mcnt = 0;
                merr = 1'b0;
                q.delete();
            end else begin
                acc = in_valid && (out_ready || q.size() == 0);
                if (q.size() != 0 && out_ready) begin
                    e = q.pop_front();
                    total++;
                    if (out_data !== e) begin
                        bad++;
                        $display("FAIL mon_out_data got=%h want=%h",
                                 out_data, e);
                    end
                end
                if (acc) q.push_back(look(in_data));
                sw_ok = swap && (mcnt == 64) && !wr_en;
                merr = swap && !sw_ok;
                if (wr_en) begin
                    mtbl[int'(!mact)][wr_addr] = wr_data;
                    if (mcnt < 64) mcnt++;
                end
                if (sw_ok) begin
                    mact = !mact;
                    mcnt = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [23:0] got,
                       input logic [23:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        started = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_out_valid got=%b want=0", out_valid);
        end
        total++;
        if (out_data !== 24'h0) begin
            bad++;
            $display("FAIL rst_out_data got=%h want=0", out_data);
        end
        total++;
        if (active_bank !== 1'b0 || shadow_ready !== 1'b0 || swap_err !== 1'b0) begin
            bad++;
            $display("FAIL rst_flags got=%b%b%b want=000",
                     active_bank, shadow_ready, swap_err);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_in_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_identity();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = {6'h3f, 6'h2a, 6'h01, 6'h00};
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL ident_valid got=%b want=1", out_valid);
        end
        total++;
        if (out_data !== {6'h3f, 6'h2a, 6'h01, 6'h00}) begin
            bad++;
            $display("FAIL ident_data got=%h want=%h", out_data,
                     {6'h3f, 6'h2a, 6'h01, 6'h00});
        end
        tick();
    endtask

    task automatic test_bad_swap();
        for (int i = 0; i < 63; i++) begin
            wr_en = 1'b1;
            wr_addr = 6'(i);
            wr_data = 6'(i) ^ 6'h15;
            tick();
        end
        wr_en = 1'b0;
        swap = 1'b1;
        tick();
        swap = 1'b0;
        total++;
        if (swap_err !== 1'b1 || active_bank !== 1'b0) begin
            bad++;
            $display("FAIL bad_swap_err got=%b%b want=10", swap_err, active_bank);
        end
        in_valid = 1'b1;
        in_data = {6'h3f, 6'h2a, 6'h01, 6'h00};
        tick();
        in_valid = 1'b0;
        total++;
        if (swap_err !== 1'b0) begin
            bad++;
            $display("FAIL bad_swap_pulse got=%b want=0", swap_err);
        end
        chk("bad_swap_lookup", out_data, {6'h3f, 6'h2a, 6'h01, 6'h00});
        wr_en = 1'b1;
        wr_addr = 6'h3f;
        wr_data = 6'h3f ^ 6'h15;
        swap = 1'b1;
        tick();
        wr_en = 1'b0;
        swap = 1'b0;
        total++;
        if (swap_err !== 1'b1 || active_bank !== 1'b0 || shadow_ready !== 1'b1) begin
            bad++;
            $display("FAIL bad_swap_last got=%b%b%b want=101",
                     swap_err, active_bank, shadow_ready);
        end
        tick();
    endtask

    task automatic test_swap_same_cycle();
        wr_en = 1'b1;
        wr_addr = 6'h3f;
        wr_data = 6'h3f ^ 6'h15;
        swap = 1'b1;
        tick();
        wr_en = 1'b0;
        total++;
        if (swap_err !== 1'b1 || active_bank !== 1'b0) begin
            bad++;
            $display("FAIL swap_wr_err got=%b%b want=10", swap_err, active_bank);
        end
        in_valid = 1'b1;
        in_data = {4{6'h05}};
        tick();
        swap = 1'b0;
        total++;
        if (active_bank !== 1'b1) begin
            bad++;
            $display("FAIL same_cyc_active got=%b want=1", active_bank);
        end
        chk("same_cyc_old", out_data, {4{6'h05}});
        tick();
        in_valid = 1'b0;
        chk("same_cyc_new", out_data, {4{6'h10}});
        tick();
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 40; i++) begin
            wr_en = 1'b1;
            wr_addr = 6'(i);
            wr_data = 6'(i) ^ 6'h3f;
            tick();
        end
        wr_en = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = {4{6'h01}};
        tick();
        in_valid = 1'b0;
        chk("mid_held", out_data, {4{6'h14}});
        rst = 1'b1;
        in_valid = 1'b1;
        wr_en = 1'b1;
        wr_addr = 6'h00;
        wr_data = 6'h00;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        wr_en = 1'b0;
        out_ready = 1'b1;
        total++;
        if (out_valid !== 1'b0 || active_bank !== 1'b0 || shadow_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst got=%b%b%b want=000",
                     out_valid, active_bank, shadow_ready);
        end
        in_valid = 1'b1;
        in_data = {6'h28, 6'h27, 6'h01, 6'h00};
        tick();
        in_valid = 1'b0;
        chk("mid_retained", out_data, {6'h28, 6'h18, 6'h3e, 6'h3f});
        tick();
    endtask

    task automatic test_swap();
        for (int i = 0; i < 64; i++) begin
            wr_en = 1'b1;
            wr_addr = 6'(i);
            wr_data = 6'(i) ^ 6'h15;
            tick();
            if (i == 62) chk("swap_not_ready", 24'(shadow_ready), 24'h0);
        end
        wr_en = 1'b0;
        chk("swap_ready", 24'(shadow_ready), 24'h1);
        swap = 1'b1;
        tick();
        swap = 1'b0;
        total++;
        if (active_bank !== 1'b1 || shadow_ready !== 1'b0 || swap_err !== 1'b0) begin
            bad++;
            $display("FAIL swap_state got=%b%b%b want=100",
                     active_bank, shadow_ready, swap_err);
        end
        in_valid = 1'b1;
        in_data = {6'h3f, 6'h00, 6'h3f, 6'h00};
        tick();
        in_valid = 1'b0;
        chk("swap_lookup", out_data, {6'h2a, 6'h15, 6'h2a, 6'h15});
        tick();
    endtask

    task automatic test_stall();
        logic [23:0] held;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = {6'h04, 6'h03, 6'h02, 6'h01};
        held = look(in_data);
        tick();
        chk("stall_first", out_data, {6'h11, 6'h16, 6'h17, 6'h14});
        in_data = {6'h08, 6'h07, 6'h06, 6'h05};
        for (int c = 0; c < 5; c++) begin
            wr_en = (c == 1);
            wr_addr = 6'h01;
            wr_data = 6'h33;
            swap = (c == 2);
            tick();
            chk("stall_in_ready", 24'(in_ready), 24'h0);
            chk("stall_frozen", out_data, held);
        end
        wr_en = 1'b0;
        swap = 1'b0;
        out_ready = 1'b1;
        tick();
        in_data = {6'h0c, 6'h0b, 6'h0a, 6'h09};
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("stall_drained", 24'(q.size()), 24'h0);
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 400; c++) begin
            in_valid = 1'($urandom_range(0, 3) != 0);
            in_data = 24'($urandom);
            out_ready = 1'($urandom_range(0, 3) != 0);
            wr_en = 1'($urandom_range(0, 1));
            wr_addr = 6'($urandom);
            wr_data = 6'($urandom);
            swap = 1'($urandom_range(0, 15) == 0);
            tick();
        end
        in_valid = 1'b0;
        wr_en = 1'b0;
        swap = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("b2b_drained", 24'(q.size()), 24'h0);
    endtask

    initial begin
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 64; i++) begin
                mtbl[b][i] = 6'(i);
            end
        end
        test_reset();
        test_identity();
        test_bad_swap();
        test_swap_same_cycle();
        test_reset_midstream();
        test_swap();
        test_stall();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
